// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths: frame state
// encoding, payload width and the default bit period.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Payload bits per frame; only 8 is supported by the serializers.
   localparam int unsigned DATA_BITS = 8;

   // 50 MHz system clock / 115200 baud.
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; o_tick is high on
// the last cycle of each bit period. i_clear holds the count at zero.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   i_clear  in   synchronous clear, holds the counter at 0
//   o_tick   out  high while the count equals CLKS_PER_BIT-1
//   o_cnt    out  current count value
// ---------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned  CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tick;

   assign w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = w_tick;
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// UART transmit serializer. Pops bytes from a show-ahead TX FIFO and sends
// them LSB first as start / 8 data / [parity] / stop. All outputs are flops.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   fifo_empty     in   TX FIFO holds no byte
//   fifo_data      in   head-of-FIFO byte, valid while fifo_empty=0
//   fifo_read_req  out  one-cycle pop strobe
//   tx             out  serial line, idle high
//   busy           out  high from first START cycle to last STOP cycle
//   tx_done        out  one-cycle pulse on the final STOP cycle
// ---------------------------------------------------------------------------
module uart_tx_engine #(
   parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_read_req,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);
   import uart_pkg::*;

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   uart_state_t          r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [IDX_W-1:0]     r_bit_idx;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_read_req;
   logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   logic             w_tick;
   logic [CNT_W-1:0] w_cnt;
   logic             w_baud_clr;
   logic             w_stop_pre;

   // Counter sits at 0 in IDLE so START always gets a full bit period; every
   // other state change happens on a tick, where the counter wraps anyway.
   assign w_baud_clr = (r_state == ST_IDLE);

   // One cycle before the end of STOP, so the registered tx_done lands on
   // the final STOP cycle.
   assign w_stop_pre = (w_cnt == CNT_W'(CLKS_PER_BIT - 2));

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_baud_clr),
      .o_tick  (w_tick),
      .o_cnt   (w_cnt)
   );

   // tx is assigned the value of the state being entered, keeping it
   // aligned with r_state while still coming straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_read_req <= 1'b0;
         r_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_read_req <= 1'b0;
         r_tx_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (!fifo_empty) begin
                  r_shift    <= fifo_data;
`ifdef UART_TX_PARITY_EN
                  r_parity   <= ^fifo_data;
`endif
                  r_read_req <= 1'b1;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= ST_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     // Next bit is the one that becomes shift_reg[0] this edge.
                     r_tx      <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_tx    <= 1'b1;
                  r_state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_tx_done <= w_stop_pre;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign fifo_read_req = r_read_req;
   assign tx            = r_tx;
   assign busy          = r_busy;
   assign tx_done       = r_tx_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine with CLKS_PER_BIT=4 and a small queue
// standing in for the show-ahead TX FIFO.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
   localparam int unsigned NPOPS = 8;
`else
   localparam int unsigned NBITS = 10;
   localparam int unsigned NPOPS = 6;
`endif
   localparam int unsigned F = CPB * NBITS;

   logic       clk = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read_req;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int         n_vec  = 0;
   int         n_err  = 0;
   int         cyc    = 0;
   int         n_pops = 0;
   logic       ovr    = 1'b0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   uart_tx_engine #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_empty    (fifo_empty),
      .fifo_data     (fifo_data),
      .fifo_read_req (fifo_read_req),
      .tx            (tx),
      .busy          (busy),
      .tx_done       (tx_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_model();
      fifo_empty = (q.size() == 0);
      fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   // Advance one clock; pop the model FIFO if the DUT strobed last cycle.
   task automatic step();
      logic rr;
      rr = fifo_read_req;
      @(posedge clk);
      #1;
      cyc++;
      if (rr === 1'b1) begin
         n_pops++;
         if (q.size() != 0) q.delete(0);
      end
      if (!ovr) drive_model();
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      logic [10:0] bits;
      bits = {1'b1, 1'b1, b, 1'b0};
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      return bits[idx];
   endfunction

   task automatic frame_check(input string tag, input logic [7:0] b, input bit perturb,
                              output int pop_cyc);
      for (int k = 0; k < 10 && fifo_read_req !== 1'b1; k++) step();
      chk({tag, "_pop"}, {31'd0, fifo_read_req}, 32'd1);
      pop_cyc = cyc;
      for (int c = 1; c <= int'(F); c++) begin
         chk({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_bit(b, (c - 1) / int'(CPB))});
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_done"}, {31'd0, tx_done}, (c == int'(F)) ? 32'd1 : 32'd0);
         chk({tag, "_req"}, {31'd0, fifo_read_req}, (c == 1) ? 32'd1 : 32'd0);
         step();
         if (perturb && (c + 1) < int'(F)) begin
            ovr        = 1'b1;
            fifo_empty = c[0];
            fifo_data  = ~b ^ 8'(c);
         end else if (ovr) begin
            ovr = 1'b0;
            drive_model();
         end
      end
      chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_idle_done"}, {31'd0, tx_done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      int   t1;
      logic quiet;

      reset      = 1'b1;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, fifo_read_req}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
      reset = 1'b0;
      step();
      step();

      // Single byte 0xA5.
      q.push_back(8'hA5);
      drive_model();
      frame_check("a5", 8'hA5, 1'b0, t0);

      // Back-to-back 0x00 then 0xFF: one idle cycle between frames.
      q.push_back(8'h00);
      q.push_back(8'hFF);
      drive_model();
      frame_check("b00", 8'h00, 1'b0, t0);
      frame_check("bff", 8'hFF, 1'b0, t1);
      chk("pop_gap", t1 - t0, F + 1);

      // Empty FIFO for 200 cycles.
      quiet = 1'b1;
      repeat (200) begin
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_req !== 1'b0 || tx_done !== 1'b0)
            quiet = 1'b0;
         step();
      end
      chk("idle_quiet", {31'd0, quiet}, 32'd1);

      // Reset during data bit 3 of 0x3C.
      q.push_back(8'h3C);
      drive_model();
      for (int k = 0; k < 10 && fifo_read_req !== 1'b1; k++) step();
      chk("r3c_pop", {31'd0, fifo_read_req}, 32'd1);
      repeat (9) step();
      chk("r3c_bit1", {31'd0, tx}, 32'd0);
      repeat (8) step();
      chk("r3c_bit3_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("r3c_async_tx", {31'd0, tx}, 32'd1);
      chk("r3c_async_busy", {31'd0, busy}, 32'd0);
      chk("r3c_async_req", {31'd0, fifo_read_req}, 32'd0);
      repeat (3) begin
         step();
         chk("r3c_hold_req", {31'd0, fifo_read_req}, 32'd0);
      end
      reset = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_req !== 1'b0) quiet = 1'b0;
      end
      chk("r3c_post_quiet", {31'd0, quiet}, 32'd1);

      // Clean frame after the abandoned one.
      q.push_back(8'h81);
      drive_model();
      frame_check("post_rst", 8'h81, 1'b0, t0);

      // FIFO inputs disturbed mid-frame must not affect the latched byte.
      q.push_back(8'h96);
      drive_model();
      frame_check("pert", 8'h96, 1'b1, t0);

`ifdef UART_TX_PARITY_EN
      q.push_back(8'h07);
      drive_model();
      frame_check("par07", 8'h07, 1'b0, t0);
      q.push_back(8'h03);
      drive_model();
      frame_check("par03", 8'h03, 1'b0, t0);
`endif

      repeat (5) step();
      chk("pop_count", n_pops, NPOPS);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
